// File: rtl/sample_stash.sv
// Circular store of the last DEPTH samples; each write becomes the displayed sample, next_sample browses history.
// Optional macro STASH_NEXT_EDGE_EN: advance once per rising edge of next_sample instead of once per high cycle.
module sample_stash #(
    parameter int unsigned DEPTH = 5,
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_sample_in,
    input  logic             i_sample_in_valid,
    input  logic             i_next_sample,
    output logic [WIDTH-1:0] o_sample_out
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wp;
    logic [PW-1:0]    r_rp;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sample_out;

    logic [PW-1:0]    w_wp_nxt;
    logic [PW-1:0]    w_rp_nxt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] w_out_nxt;
    logic             w_next_evt;

`ifdef STASH_NEXT_EDGE_EN
    // Previous next_sample level; resets low so a strobe held through reset release is not an edge.
    logic r_next_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_next_d <= 1'b0;
        end else begin
            r_next_d <= i_next_sample;
        end
    end

    assign w_next_evt = i_next_sample & ~r_next_d;
`else
    assign w_next_evt = i_next_sample;
`endif

    // Next pointer/count/display state; a write always takes priority over navigation.
    always_comb begin
        w_wp_nxt  = r_wp;
        w_rp_nxt  = r_rp;
        w_cnt_nxt = r_cnt;
        w_out_nxt = r_sample_out;
        if (i_sample_in_valid) begin
            w_rp_nxt  = r_wp;
            w_wp_nxt  = (r_wp == PW'(DEPTH - 1)) ? '0 : r_wp + PW'(1);
            w_cnt_nxt = (r_cnt == CW'(DEPTH)) ? r_cnt : r_cnt + CW'(1);
            w_out_nxt = i_sample_in;
        end else if (w_next_evt && (r_cnt != '0)) begin
            w_rp_nxt  = ((CW'(r_rp) + CW'(1)) >= r_cnt) ? '0 : r_rp + PW'(1);
            w_out_nxt = r_mem[w_rp_nxt];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wp         <= '0;
            r_rp         <= '0;
            r_cnt        <= '0;
            r_sample_out <= '0;
        end else begin
            r_wp         <= w_wp_nxt;
            r_rp         <= w_rp_nxt;
            r_cnt        <= w_cnt_nxt;
            r_sample_out <= w_out_nxt;
        end
    end

    // One register per slot, each loaded only when the write pointer selects it.
    for (genvar g = 0; g < DEPTH; g++) begin : g_slot
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_mem[g] <= '0;
            end else if (i_sample_in_valid && (r_wp == PW'(g))) begin
                r_mem[g] <= i_sample_in;
            end
        end
    end

    assign o_sample_out = r_sample_out;

endmodule

// File: tb/tb_sample_stash.sv
// Self-checking bench for sample_stash: directed test-plan steps followed by random traffic against a history model.
module tb_sample_stash;

    localparam int unsigned DEPTH = 5;
    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [WIDTH-1:0] sample_in;
    logic             sample_in_valid;
    logic             next_sample;
    logic [WIDTH-1:0] sample_out;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: full write history in order; sample k lives in slot k % DEPTH; sel is the displayed slot.
    int hist[$];
    int sel;
    bit prev_next;

    sample_stash #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_sample_in      (sample_in),
        .i_sample_in_valid(sample_in_valid),
        .i_next_sample    (next_sample),
        .o_sample_out     (sample_out)
    );

    always #5 clk = ~clk;

    function automatic int model_out();
        if (hist.size() == 0) return 0;
        for (int k = hist.size() - 1; k >= 0; k--) begin
            if ((k % int'(DEPTH)) == sel) return hist[k];
        end
        return 0;
    endfunction

    task automatic model_reset();
        hist.delete();
        sel       = 0;
        prev_next = 1'b0;
    endtask

    task automatic model_edge(input bit v, input int d, input bit n);
        bit evt;
        int lim;
`ifdef STASH_NEXT_EDGE_EN
        evt       = n && !prev_next;
        prev_next = n;
`else
        evt = n;
`endif
        if (v) begin
            hist.push_back(d);
            sel = (hist.size() - 1) % int'(DEPTH);
        end else if (evt && hist.size() > 0) begin
            lim = (hist.size() < int'(DEPTH)) ? hist.size() : int'(DEPTH);
            sel = (sel + 1) % lim;
        end
    endtask

    task automatic check(input string tag, input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (sample_out === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, sample_out, exp);
        end
    endtask

    // Apply one cycle of inputs, advance model, compare against the model.
    task automatic step(input bit v, input int d, input bit n, input string tag);
        sample_in_valid = v;
        sample_in       = WIDTH'(d);
        next_sample     = n;
        @(posedge clk);
        model_edge(v, d, n);
        #1;
        check(tag, WIDTH'(model_out()));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("reset_async", '0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b1;
        sample_in       = '0;
        sample_in_valid = 1'b0;
        next_sample     = 1'b0;
        model_reset();
        #2;
        do_reset();
        step(0, 0, 0, "reset_idle");
        check("reset_const", '0);

        // Fill 1..5, then overwrite with 6
        for (int i = 1; i <= 5; i++) begin
            step(1, i, 0, "fill");
            check("fill_const", WIDTH'(i));
        end
        step(1, 6, 0, "overwrite");
        check("overwrite_const", 8'd6);
        step(0, 0, 0, "idle");

        // Navigate with gaps: 2,3,4,5,6
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, "nav_wrap");
            check("nav_wrap_const", WIDTH'(i + 2));
            step(0, 0, 0, "nav_gap");
        end

        // Empty next, then partial fill wrap at cnt=3
        do_reset();
        step(0, 0, 1, "empty_next");
        check("empty_next_const", '0);
        step(0, 0, 0, "idle");
        step(1, 10, 0, "pf_w");
        step(1, 20, 0, "pf_w");
        step(1, 30, 0, "pf_w");
        check("pf_last_const", 8'd30);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 1, "pf_nav");
            check("pf_nav_const", WIDTH'((i + 1) * 10));
            step(0, 0, 0, "pf_gap");
        end

        // Collision: write wins
        step(1, 7, 1, "collision");
        check("collision_const", 8'd7);
        step(0, 0, 0, "idle");
        step(0, 0, 1, "after_coll");
        check("after_coll_const", 8'd10);

        // Reset during a navigate pulse
        next_sample = 1'b1;
        do_reset();
        next_sample = 1'b0;
        step(0, 0, 0, "post_rst");
        step(1, 9, 0, "w9");
        check("w9_const", 8'd9);
        step(0, 0, 0, "idle");
        step(0, 0, 1, "w9_nav");
        check("w9_nav_const", 8'd9);
        step(0, 0, 0, "idle");

        // Random traffic with occasional reset
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end
            step($urandom_range(0, 3) == 0, int'($urandom_range(0, 255)),
                 $urandom_range(0, 1) == 1, "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sample_stash.md
Name: sample_stash

Overview:
- Small circular sample store ("stash") that keeps the last DEPTH accepted samples.
- Each accepted sample becomes the displayed sample.
- A user-facing next_sample strobe steps the display through the stored samples, oldest-after-current first, wrapping around.
- Sits between a sample producer (e.g. a sampled input or sensor path) and a display/readout stage.

Parameters:
- DEPTH, 5, number of stored samples; legal range 2..256.
- WIDTH, 8, sample width in bits.

Ports:
- clk  input  1  single system clock; all state updates on rising edge.
- reset  input  1  one clock; reset is asynchronous and active-low.
- sample_in  input  WIDTH  sample to store.
- sample_in_valid  input  1  high for one or more cycles; each cycle high stores sample_in.
- next_sample  input  1  advance the read pointer.
- sample_out  output  WIDTH  currently selected stored sample.

Behaviour:
- State:
  - storage array mem[0..DEPTH-1]
  - write pointer wp
  - read pointer rp
  - fill count cnt (0..DEPTH)
  - pointer width clog2(DEPTH), min 1.
- Reset (reset low, asynchronous assert, synchronous-to-clk release):
  - all mem entries = 0, wp = 0, rp = 0, cnt = 0.
  - sample_out = 0 immediately.
- Write (sample_in_valid high at rising edge):
  - mem[wp] <= sample_in
  - rp <= wp
  - wp <= (wp == DEPTH-1) ? 0 : wp+1
  - cnt <= min(cnt+1, DEPTH)
- Overwrite: when full, the write replaces the oldest entry (slot wp). No full flag, no stall, no error.
- Navigate (next_sample high at rising edge, sample_in_valid low):
  - if cnt == 0: no change.
  - else rp <= (rp+1 >= cnt) ? 0 : rp+1, i.e. wrap limit is cnt while filling and DEPTH once full.
  - Level-sensitive by default: advances once per clock cycle that next_sample is high.
- Simultaneous write and next_sample: the write wins; next_sample is ignored that cycle.
- sample_out:
  - combinational read of mem[rp]; 0 when cnt == 0.
  - Latency: stored value visible right after the storing edge (same cycle as rp update).
- Navigation order when full after k writes: sequence continues from the most recent slot through the older slots in slot order, wrapping. E.g. DEPTH=5, writes 1..6 → mem = [6,2,3,4,5], rp = 0; nexts show 2,3,4,5,6.
- Reset mid-operation: all state cleared regardless of pending valid/next.
- Inputs are assumed synchronous to clk; no internal synchronisers.

Optional Feature:
- Macro STASH_NEXT_EDGE_EN.
- Defined: next_sample is registered and rising-edge detected; rp advances exactly once per 0→1 transition regardless of pulse length. The edge register resets to 0, so a next_sample held high through reset release does not advance.
- Undefined: level-sensitive, one advance per cycle high, as above.

Test Plan:
- Reset: hold reset low 1 cycle, release → sample_out = 0, no writes or advances occur.
- Fill: write 1,2,3,4,5 on consecutive cycles (valid 1 cycle each) → sample_out reads 1,2,3,4,5 after each edge.
- Overwrite: sixth write of 6 → sample_out = 6; slot 0 holds 6.
- Navigate wrap: five single-cycle next_sample pulses with idle cycles between → sample_out 2,3,4,5,6.
- Partial fill: after reset, write 10,20,30; pulse next 3 times → 10,20,30 (wrap at cnt=3). With cnt=0, next_sample leaves sample_out = 0.
- Collision and reset mid-run: sample_in_valid=1 (value 7) with next_sample=1 → sample_out = 7, rp = slot just written. Then assert reset during a navigate pulse → sample_out = 0 immediately; subsequent write of 9 → 9 at slot 0.
